riscv_hwloop_sequencer: RTL and testbench

//  Sequencer for the two hardware-loop register sets (start/end/counter x2) in the ID stage.

---
 rtl/riscv_hwlp_pkg.sv | 22 ++
 rtl/riscv_hwloop_sequencer_if.sv | 27 ++
 rtl/riscv_hwloop_match.sv | 22 ++
 rtl/riscv_hwloop_sequencer.sv | 154 +++++++++++++++
 tb/tb_riscv_hwloop_sequencer.sv | 262 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/riscv_hwlp_pkg.sv
// Shared constants and types for the hardware-loop sequencer.
//   hwlp_state_t : setup FSM state encoding (IDLE/WRITE/SETTLE)
//   HWLP_WE_ALL  : write-enable pattern {cnt,end,start}
//   HWLP_LOOP0/1 : loop set indices (loop 0 is the inner, higher-priority loop)
package riscv_hwlp_pkg;

  localparam int unsigned HWLP_N_REGS = 2;
  localparam int unsigned HWLP_ADDR_W = 32;
  localparam int unsigned HWLP_ST_W   = 2;

  typedef logic [HWLP_ST_W-1:0] hwlp_state_t;

  localparam hwlp_state_t IDLE   = 2'd0;
  localparam hwlp_state_t WRITE  = 2'd1;
  localparam hwlp_state_t SETTLE = 2'd2;

  localparam logic [2:0] HWLP_WE_ALL = 3'b111;

  localparam int unsigned HWLP_LOOP0 = 0;
  localparam int unsigned HWLP_LOOP1 = 1;

endpackage

// File: rtl/riscv_hwloop_sequencer_if.sv
// Loop-setup request channel.
//   setup_req   : request, held by the requester until setup_ack
//   setup_regid : target loop set
//   setup_start / setup_end / setup_cnt : loop start, last body address, iteration count
//   setup_ack   : one-cycle accept pulse from the sequencer
interface riscv_hwloop_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);

  logic              setup_req;
  logic              setup_regid;
  logic [ADDR_W-1:0] setup_start;
  logic [ADDR_W-1:0] setup_end;
  logic [ADDR_W-1:0] setup_cnt;
  logic              setup_ack;

  modport master (
    output setup_req, setup_regid, setup_start, setup_end, setup_cnt,
    input  setup_ack
  );

  modport slave (
    input  setup_req, setup_regid, setup_start, setup_end, setup_cnt,
    output setup_ack
  );

endinterface

// File: rtl/riscv_hwloop_match.sv
// Per-loop end-of-body detector.
//   armed_i, pc_valid_i, pc_i : loop armed flag and issuing PC
//   end_i, cnt_i              : loop end address and current counter
//   hit_c_o                   : PC sits on an active loop's last instruction
//   gt1_c_o                   : counter > 1, i.e. another iteration follows
module riscv_hwloop_match #(
  parameter int unsigned ADDR_W = 32
) (
  input  logic              armed_i,
  input  logic              pc_valid_i,
  input  logic [ADDR_W-1:0] pc_i,
  input  logic [ADDR_W-1:0] end_i,
  input  logic [ADDR_W-1:0] cnt_i,
  output logic              hit_c_o,
  output logic              gt1_c_o
);

  // A zero counter marks the loop inactive.
  assign hit_c_o = armed_i & pc_valid_i & (pc_i == end_i) & (cnt_i != '0);
  assign gt1_c_o = (cnt_i > ADDR_W'(1));

endmodule

// File: rtl/riscv_hwloop_sequencer.sv
// Hardware-loop sequencer for the ID stage.
//   clk, rst            : clock, asynchronous active-high reset
//   setup_if            : loop-setup request channel (slave side)
//   hwlp_we_o/regid_o/*_data_o : write port into the loop register file
//   hwlp_{start,end,cnt}_{0,1}_i : current loop register contents
//   pc_i, pc_valid_i, id_valid_i, flush_i : ID-stage instruction status
//   hwlp_dec_cnt_o      : one-hot counter decrement request
//   hwlp_jump_o, hwlp_targ_addr_o : fetch redirect to the loop start
//   busy_o              : setup in progress
module riscv_hwloop_sequencer
  import riscv_hwlp_pkg::*;
#(
  parameter int unsigned N_REGS = HWLP_N_REGS,
  parameter int unsigned ADDR_W = HWLP_ADDR_W
) (
  input  logic                    clk,
  input  logic                    rst,
  riscv_hwloop_sequencer_if.slave setup_if,
  output logic [2:0]              hwlp_we_o,
  output logic                    hwlp_regid_o,
  output logic [ADDR_W-1:0]       hwlp_start_data_o,
  output logic [ADDR_W-1:0]       hwlp_end_data_o,
  output logic [ADDR_W-1:0]       hwlp_cnt_data_o,
  input  logic [ADDR_W-1:0]       hwlp_start_0_i,
  input  logic [ADDR_W-1:0]       hwlp_start_1_i,
  input  logic [ADDR_W-1:0]       hwlp_end_0_i,
  input  logic [ADDR_W-1:0]       hwlp_end_1_i,
  input  logic [ADDR_W-1:0]       hwlp_cnt_0_i,
  input  logic [ADDR_W-1:0]       hwlp_cnt_1_i,
  input  logic [ADDR_W-1:0]       pc_i,
  input  logic                    pc_valid_i,
  input  logic                    id_valid_i,
  input  logic                    flush_i,
  output logic [1:0]              hwlp_dec_cnt_o,
  output logic                    hwlp_jump_o,
  output logic [ADDR_W-1:0]       hwlp_targ_addr_o,
  output logic                    busy_o
);

  hwlp_state_t       state_q, state_d;
  logic [N_REGS-1:0] armed_q, armed_d;
  logic              jump_done_q, jump_done_d;
  logic              regid_q;
  logic [ADDR_W-1:0] start_q, end_q, cnt_q;
  logic              latch_c;
  logic              ack_c;
  logic [2:0]        we_c;
  logic              busy_c;

  logic hit0_c, hit1_c, gt1_0_c, gt1_1_c;
  logic sel1_c, gt1_sel_c, jump_c;

  // Setup FSM: next state, armed flags and state-decoded outputs.
  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    latch_c = 1'b0;
    ack_c   = 1'b0;
    we_c    = 3'b000;
    busy_c  = 1'b0;
    case (state_q)
      IDLE: begin
        if (setup_if.setup_req) begin
          latch_c                        = 1'b1;
          armed_d[setup_if.setup_regid]  = 1'b0;
          state_d                        = WRITE;
        end
      end
      WRITE: begin
        ack_c   = 1'b1;
        we_c    = HWLP_WE_ALL;
        busy_c  = 1'b1;
        state_d = SETTLE;
      end
      SETTLE: begin
        // Register file holds the new values from here on; safe to arm.
        busy_c           = 1'b1;
        armed_d[regid_q] = 1'b1;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      armed_q     <= '0;
      jump_done_q <= 1'b0;
      regid_q     <= 1'b0;
      start_q     <= '0;
      end_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      armed_q     <= armed_d;
      jump_done_q <= jump_done_d;
      if (latch_c) begin
        regid_q <= setup_if.setup_regid;
        start_q <= setup_if.setup_start;
        end_q   <= setup_if.setup_end;
        cnt_q   <= setup_if.setup_cnt;
      end
    end
  end

  riscv_hwloop_match #(.ADDR_W(ADDR_W)) u_match0 (
    .armed_i    (armed_q[HWLP_LOOP0]),
    .pc_valid_i (pc_valid_i),
    .pc_i       (pc_i),
    .end_i      (hwlp_end_0_i),
    .cnt_i      (hwlp_cnt_0_i),
    .hit_c_o    (hit0_c),
    .gt1_c_o    (gt1_0_c)
  );

  riscv_hwloop_match #(.ADDR_W(ADDR_W)) u_match1 (
    .armed_i    (armed_q[HWLP_LOOP1]),
    .pc_valid_i (pc_valid_i),
    .pc_i       (pc_i),
    .end_i      (hwlp_end_1_i),
    .cnt_i      (hwlp_cnt_1_i),
    .hit_c_o    (hit1_c),
    .gt1_c_o    (gt1_1_c)
  );

  // Inner loop wins when both loops end on the same instruction.
  assign sel1_c    = hit1_c & ~hit0_c;
  assign gt1_sel_c = hit0_c ? gt1_0_c : gt1_1_c;
  assign jump_c    = (hit0_c | hit1_c) & gt1_sel_c & ~jump_done_q & ~flush_i;

  // One redirect per instruction: held off across ID stalls until it leaves or is flushed.
  always_comb begin
    jump_done_d = jump_done_q;
    if (id_valid_i || flush_i) begin
      jump_done_d = 1'b0;
    end else if (jump_c) begin
      jump_done_d = 1'b1;
    end
  end

  assign setup_if.setup_ack = ack_c;
  assign hwlp_we_o          = we_c;
  assign busy_o             = busy_c;
  assign hwlp_regid_o       = regid_q;
  assign hwlp_start_data_o  = start_q;
  assign hwlp_end_data_o    = end_q;
  assign hwlp_cnt_data_o    = cnt_q;

  assign hwlp_dec_cnt_o   = flush_i ? 2'b00 : {sel1_c, hit0_c};
  assign hwlp_jump_o      = jump_c;
  assign hwlp_targ_addr_o = !jump_c ? '0 : (hit0_c ? hwlp_start_0_i : hwlp_start_1_i);

endmodule

// File: tb/tb_riscv_hwloop_sequencer.sv
// Directed self-checking bench for riscv_hwloop_sequencer.
module tb_riscv_hwloop_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  hwlp_we;
  logic        hwlp_regid;
  logic [31:0] start_data, end_data, cnt_data;
  logic [31:0] start0, start1, end0, end1, cnt0, cnt1;
  logic [31:0] pc;
  logic        pc_valid, id_valid, flush;
  logic [1:0]  dec;
  logic        jump;
  logic [31:0] targ;
  logic        busy;

  int n_chk  = 0;
  int n_pass = 0;

  riscv_hwloop_sequencer_if #(.ADDR_W(32)) sif ();

  riscv_hwloop_sequencer #(.N_REGS(2), .ADDR_W(32)) dut (
    .clk               (clk),
    .rst               (rst),
    .setup_if          (sif),
    .hwlp_we_o         (hwlp_we),
    .hwlp_regid_o      (hwlp_regid),
    .hwlp_start_data_o (start_data),
    .hwlp_end_data_o   (end_data),
    .hwlp_cnt_data_o   (cnt_data),
    .hwlp_start_0_i    (start0),
    .hwlp_start_1_i    (start1),
    .hwlp_end_0_i      (end0),
    .hwlp_end_1_i      (end1),
    .hwlp_cnt_0_i      (cnt0),
    .hwlp_cnt_1_i      (cnt1),
    .pc_i              (pc),
    .pc_valid_i        (pc_valid),
    .id_valid_i        (id_valid),
    .flush_i           (flush),
    .hwlp_dec_cnt_o    (dec),
    .hwlp_jump_o       (jump),
    .hwlp_targ_addr_o  (targ),
    .busy_o            (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] pc;
    logic        pv, iv, fl;
    logic [31:0] s0, e0, c0, s1, e1, c1;
    logic [1:0]  dec;
    logic        jump;
    logic [31:0] targ;
  } vec_t;

  vec_t vecs[14];

  function automatic vec_t mk(input logic [31:0] p, input logic pv, iv, fl,
                              input logic [31:0] s0, e0, c0, s1, e1, c1,
                              input logic [1:0] d, input logic j, input logic [31:0] t);
    vec_t v;
    v.pc = p; v.pv = pv; v.iv = iv; v.fl = fl;
    v.s0 = s0; v.e0 = e0; v.c0 = c0; v.s1 = s1; v.e1 = e1; v.c1 = c1;
    v.dec = d; v.jump = j; v.targ = t;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full setup handshake; checks the write pulse, data and the busy window.
  task automatic do_setup(input logic r, input logic [31:0] s, e, c);
    sif.setup_req   = 1'b1;
    sif.setup_regid = r;
    sif.setup_start = s;
    sif.setup_end   = e;
    sif.setup_cnt   = c;
    step();
    chk("su_ack", 32'(sif.setup_ack), 32'd1);
    chk("su_we", 32'(hwlp_we), 32'd7);
    chk("su_regid", 32'(hwlp_regid), 32'(r));
    chk("su_start", start_data, s);
    chk("su_end", end_data, e);
    chk("su_cnt", cnt_data, c);
    chk("su_dec_masked", 32'(dec[r]), 32'd0);
    sif.setup_req = 1'b0;
    step();
    chk("su_settle_busy", 32'(busy), 32'd1);
    chk("su_settle_we", 32'(hwlp_we), 32'd0);
    step();
    chk("su_idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    vecs[0]  = mk(32'h10C, 1, 0, 0, 32'h100, 32'h10C, 3, 32'h280, 32'h300, 4, 2'b01, 1, 32'h100);
    vecs[1]  = mk(32'h10C, 1, 0, 0, 32'h100, 32'h10C, 1, 32'h280, 32'h300, 4, 2'b01, 0, 32'h0);
    vecs[2]  = mk(32'h10C, 1, 0, 0, 32'h100, 32'h10C, 0, 32'h280, 32'h300, 4, 2'b00, 0, 32'h0);
    vecs[3]  = mk(32'h10C, 0, 0, 0, 32'h100, 32'h10C, 3, 32'h280, 32'h300, 4, 2'b00, 0, 32'h0);
    vecs[4]  = mk(32'h300, 1, 0, 0, 32'h100, 32'h10C, 3, 32'h280, 32'h300, 4, 2'b10, 1, 32'h280);
    vecs[5]  = mk(32'h300, 1, 0, 0, 32'h100, 32'h10C, 3, 32'h280, 32'h300, 1, 2'b10, 0, 32'h0);
    vecs[6]  = mk(32'h200, 1, 0, 0, 32'h1C0, 32'h200, 2, 32'h180, 32'h200, 5, 2'b01, 1, 32'h1C0);
    vecs[7]  = mk(32'h200, 1, 0, 0, 32'h1C0, 32'h200, 0, 32'h180, 32'h200, 5, 2'b10, 1, 32'h180);
    vecs[8]  = mk(32'h10C, 1, 0, 1, 32'h100, 32'h10C, 3, 32'h280, 32'h300, 4, 2'b00, 0, 32'h0);
    vecs[9]  = mk(32'h10C, 1, 1, 1, 32'h100, 32'h10C, 3, 32'h280, 32'h300, 4, 2'b00, 0, 32'h0);
    vecs[10] = mk(32'h108, 1, 0, 0, 32'h100, 32'h10C, 3, 32'h280, 32'h300, 4, 2'b00, 0, 32'h0);
    vecs[11] = mk(32'h10C, 1, 0, 0, 32'h100, 32'h10C, 32'hFFFF_FFFF, 32'h280, 32'h300, 4, 2'b01, 1, 32'h100);
    vecs[12] = mk(32'h10C, 1, 1, 0, 32'h100, 32'h10C, 2, 32'h280, 32'h300, 4, 2'b01, 1, 32'h100);
    vecs[13] = mk(32'h300, 1, 0, 0, 32'h100, 32'h10C, 3, 32'h280, 32'h300, 0, 2'b00, 0, 32'h0);

    rst = 1'b1;
    sif.setup_req = 1'b0; sif.setup_regid = 1'b0;
    sif.setup_start = '0; sif.setup_end = '0; sif.setup_cnt = '0;
    start0 = '0; start1 = '0; end0 = '0; end1 = '0; cnt0 = '0; cnt1 = '0;
    pc = '0; pc_valid = 1'b0; id_valid = 1'b0; flush = 1'b0;
    step();
    step();
    rst = 1'b0;
    #1;
    chk("rst_we", 32'(hwlp_we), 32'd0);
    chk("rst_ack", 32'(sif.setup_ack), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_dec", 32'(dec), 32'd0);
    chk("rst_jump", 32'(jump), 32'd0);
    chk("rst_targ", targ, 32'd0);
    chk("rst_data", start_data | end_data | cnt_data, 32'd0);

    // Setup loop 0 while PC already sits on its end: nothing fires until armed.
    start0 = 32'h100; end0 = 32'h10C; cnt0 = 3;
    pc = 32'h10C; pc_valid = 1'b1; id_valid = 1'b0;
    sif.setup_req = 1'b1; sif.setup_regid = 1'b0;
    sif.setup_start = 32'h100; sif.setup_end = 32'h10C; sif.setup_cnt = 3;
    #1;
    chk("s1_prearm_dec", 32'(dec), 32'd0);
    chk("s1_idle_ack", 32'(sif.setup_ack), 32'd0);
    step();
    chk("s1_ack", 32'(sif.setup_ack), 32'd1);
    chk("s1_we", 32'(hwlp_we), 32'd7);
    chk("s1_busy_w", 32'(busy), 32'd1);
    chk("s1_start", start_data, 32'h100);
    chk("s1_end", end_data, 32'h10C);
    chk("s1_cnt", cnt_data, 32'd3);
    chk("s1_dec_w", 32'(dec), 32'd0);
    sif.setup_req = 1'b0;
    step();
    chk("s1_ack_s", 32'(sif.setup_ack), 32'd0);
    chk("s1_we_s", 32'(hwlp_we), 32'd0);
    chk("s1_busy_s", 32'(busy), 32'd1);
    chk("s1_dec_s", 32'(dec), 32'd0);
    chk("s1_jump_s", 32'(jump), 32'd0);

    // Armed; ID stalled for 3 cycles: single redirect, decrement strobe held.
    step();
    chk("stall0_busy", 32'(busy), 32'd0);
    chk("stall0_jump", 32'(jump), 32'd1);
    chk("stall0_targ", targ, 32'h100);
    chk("stall0_dec", 32'(dec), 32'd1);
    step();
    chk("stall1_jump", 32'(jump), 32'd0);
    chk("stall1_targ", targ, 32'd0);
    chk("stall1_dec", 32'(dec), 32'd1);
    step();
    chk("stall2_jump", 32'(jump), 32'd0);
    chk("stall2_dec", 32'(dec), 32'd1);
    id_valid = 1'b1;
    #1;
    chk("stall3_jump", 32'(jump), 32'd0);
    chk("stall3_dec", 32'(dec), 32'd1);
    step();
    chk("iter_jump", 32'(jump), 32'd1);
    chk("iter_targ", targ, 32'h100);
    step();
    chk("iter2_jump", 32'(jump), 32'd1);
    cnt0 = 1;
    #1;
    chk("last_dec", 32'(dec), 32'd1);
    chk("last_jump", 32'(jump), 32'd0);
    chk("last_targ", targ, 32'd0);

    // Flush drops the decision and clears the one-redirect guard.
    cnt0 = 3; id_valid = 1'b0;
    #1;
    chk("fl_pre_jump", 32'(jump), 32'd1);
    step();
    chk("fl_done_jump", 32'(jump), 32'd0);
    flush = 1'b1;
    #1;
    chk("fl_dec", 32'(dec), 32'd0);
    chk("fl_jump", 32'(jump), 32'd0);
    step();
    flush = 1'b0;
    #1;
    chk("fl_cleared_jump", 32'(jump), 32'd1);
    chk("fl_cleared_dec", 32'(dec), 32'd1);
    id_valid = 1'b1; pc_valid = 1'b0;
    step();

    // Arm loop 1, then re-program loop 0 while its end matches.
    do_setup(1'b1, 32'h280, 32'h300, 32'd4);
    start1 = 32'h280; end1 = 32'h300; cnt1 = 4;
    pc_valid = 1'b1;
    #1;
    chk("resu_pre_dec", 32'(dec), 32'd1);
    do_setup(1'b0, 32'h100, 32'h10C, 32'd3);
    chk("resu_post_dec", 32'(dec), 32'd1);
    pc_valid = 1'b0;
    step();

    for (int i = 0; i < 14; i++) begin
      pc = vecs[i].pc; pc_valid = vecs[i].pv; id_valid = vecs[i].iv; flush = vecs[i].fl;
      start0 = vecs[i].s0; end0 = vecs[i].e0; cnt0 = vecs[i].c0;
      start1 = vecs[i].s1; end1 = vecs[i].e1; cnt1 = vecs[i].c1;
      #1;
      chk($sformatf("vec%0d_dec", i), 32'(dec), 32'(vecs[i].dec));
      chk($sformatf("vec%0d_jump", i), 32'(jump), 32'(vecs[i].jump));
      chk($sformatf("vec%0d_targ", i), targ, vecs[i].targ);
      pc_valid = 1'b0; id_valid = 1'b1; flush = 1'b0;
      step();
    end

    // Reset in the middle of a setup write.
    start0 = 32'h100; end0 = 32'h10C; cnt0 = 3;
    pc = 32'h10C; pc_valid = 1'b1; id_valid = 1'b1;
    sif.setup_req = 1'b1; sif.setup_regid = 1'b0;
    sif.setup_start = 32'h100; sif.setup_end = 32'h10C; sif.setup_cnt = 3;
    step();
    chk("rw_we_before", 32'(hwlp_we), 32'd7);
    rst = 1'b1;
    sif.setup_req = 1'b0;
    #1;
    chk("rw_we", 32'(hwlp_we), 32'd0);
    chk("rw_ack", 32'(sif.setup_ack), 32'd0);
    chk("rw_busy", 32'(busy), 32'd0);
    chk("rw_dec", 32'(dec), 32'd0);
    step();
    rst = 1'b0;
    step();
    step();
    chk("rw_later_jump", 32'(jump), 32'd0);
    chk("rw_later_dec", 32'(dec), 32'd0);
    chk("rw_later_targ", targ, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
